// File: rtl/gpio_seq_checker.sv
// gpio_seq_checker: snoops GPIO writes to CHECK_ADDR and checks them against a programmable expected sequence
module gpio_seq_checker #(
  parameter int NR_GPIOS    = 8,
  parameter int GPIO_ADDR_W = 8,
  parameter int DEPTH       = 16,
  parameter int CHECK_ADDR  = 4,
  parameter int TIMEOUT_W   = 20
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cs_i,
  input  logic [GPIO_ADDR_W-1:0]     gpioAddr_i,
  input  logic [NR_GPIOS-1:0]        gpio_i,
  input  logic                       exp_we_i,
  input  logic [$clog2(DEPTH)-1:0]   exp_idx_i,
  input  logic [NR_GPIOS-1:0]        exp_data_i,
  input  logic [$clog2(DEPTH):0]     seq_len_i,
  input  logic                       strict_addr_i,
  input  logic [TIMEOUT_W-1:0]       timeout_i,
  input  logic                       start_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       pass_o,
  output logic                       fail_o,
  output logic [1:0]                 err_code_o,
  output logic [$clog2(DEPTH):0]     match_cnt_o,
  output logic [$clog2(DEPTH):0]     fail_idx_o,
  output logic [NR_GPIOS-1:0]        fail_data_o
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] PASS = 2'd2;
  localparam logic [1:0] FAIL = 2'd3;
  logic [1:0] state;
  logic [NR_GPIOS-1:0] tbl [DEPTH];
  logic [CW-1:0] idx, len;
  logic strict;
  logic [TIMEOUT_W-1:0] tmo, tmo_lim;
  logic hit, match, tmo_hit;
  assign hit = cs_i && gpioAddr_i == GPIO_ADDR_W'(CHECK_ADDR);
  assign match = hit && gpio_i == tbl[idx[IW-1:0]];
  assign tmo_hit = tmo_lim != '0 && tmo == tmo_lim - TIMEOUT_W'(1);
  assign busy_o = state == RUN;
  assign done_o = state == PASS || state == FAIL;
  assign pass_o = state == PASS;
  assign fail_o = state == FAIL;
  assign match_cnt_o = idx;
  always_ff @(posedge clk_i)
    if (exp_we_i && state != RUN) tbl[exp_idx_i] <= exp_data_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      idx         <= '0;
      len         <= '0;
      strict      <= 1'b0;
      tmo         <= '0;
      tmo_lim     <= '0;
      err_code_o  <= 2'd0;
      fail_idx_o  <= '0;
      fail_data_o <= '0;
    end else if (start_i) begin
      state       <= seq_len_i == '0 ? PASS : RUN;
      idx         <= '0;
      len         <= seq_len_i;
      strict      <= strict_addr_i;
      tmo         <= '0;
      tmo_lim     <= timeout_i;
      err_code_o  <= 2'd0;
      fail_idx_o  <= '0;
      fail_data_o <= '0;
    end else if (state == RUN) begin
      if (match) begin
        idx <= idx + CW'(1);
        tmo <= '0;
        if (idx + CW'(1) == len) state <= PASS;
      end else if (hit || (cs_i && strict)) begin
        state       <= FAIL;
        err_code_o  <= hit ? 2'd1 : 2'd2;
        fail_idx_o  <= idx;
        fail_data_o <= gpio_i;
      end else if (tmo_hit) begin
        state       <= FAIL;
        err_code_o  <= 2'd3;
        fail_idx_o  <= idx;
        fail_data_o <= '0;
      end else if (tmo != '1) begin
        tmo <= tmo + TIMEOUT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_gpio_seq_checker.sv
// tb_gpio_seq_checker: scoreboard bench for gpio_seq_checker
module tb_gpio_seq_checker;
  logic clk = 0, rst = 1, cs = 0, exp_we = 0, strict = 0, start = 0;
  logic [7:0] addr = 0, gpio = 0, exp_data = 0;
  logic [3:0] exp_idx = 0;
  logic [4:0] seq_len = 0;
  logic [19:0] timeout = 0;
  logic busy, done, pass, fail;
  logic [1:0] err;
  logic [4:0] cnt, fidx;
  logic [7:0] fdata;
  int total = 0, bad = 0, cyc = 0;
  logic done_q = 0;
  typedef struct {bit pass; int err; int cnt; int fidx; int fdata; int cyc;} res_t;
  res_t q[$];
  logic [7:0] seq [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h80};

  gpio_seq_checker dut (
    .clk_i(clk), .rst_i(rst), .cs_i(cs), .gpioAddr_i(addr), .gpio_i(gpio),
    .exp_we_i(exp_we), .exp_idx_i(exp_idx), .exp_data_i(exp_data),
    .seq_len_i(seq_len), .strict_addr_i(strict), .timeout_i(timeout), .start_i(start),
    .busy_o(busy), .done_o(done), .pass_o(pass), .fail_o(fail), .err_code_o(err),
    .match_cnt_o(cnt), .fail_idx_o(fidx), .fail_data_o(fdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done && !done_q) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done act=1 exp=0 at cyc %0d", cyc);
      end else begin
        res_t e;
        e = q.pop_front();
        chk("pass", pass, e.pass);
        chk("fail", fail, !e.pass);
        chk("err", err, e.err);
        chk("match_cnt", cnt, e.cnt);
        chk("fail_idx", fidx, e.fidx);
        chk("fail_data", fdata, e.fdata);
        chk("done_cycle", cyc, e.cyc);
      end
    end
    done_q = done;
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(bit p, int e, int c, int fi, int fd, int dly = 0);
    q.push_back('{p, e, c, fi, fd, cyc + 1 + dly});
  endtask

  task automatic wr(logic [7:0] a, logic [7:0] d);
    cs = 1; addr = a; gpio = d;
    tick();
    cs = 0;
  endtask

  task automatic go(int l, bit s, int t);
    start = 1; seq_len = 5'(l); strict = s; timeout = 20'(t);
    tick();
    start = 0;
  endtask

  task automatic load();
    for (int i = 0; i < 8; i++) begin
      exp_we = 1; exp_idx = 4'(i); exp_data = seq[i];
      tick();
    end
    exp_we = 0;
  endtask

  task automatic run_full_pass();
    for (int i = 0; i < 7; i++) wr(8'd4, seq[i]);
    push(1, 0, 8, 0, 0);
    wr(8'd4, seq[7]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_err", err, 0);
    rst = 0;
    load();
    // 1: full pass
    go(8, 1, 0);
    chk("busy_run", busy, 1);
    run_full_pass();
    tick(2);
    // 2: data mismatch at index 2, later writes ignored
    go(8, 1, 0);
    wr(8'd4, 8'h01);
    wr(8'd4, 8'h02);
    push(0, 1, 2, 2, 5);
    wr(8'd4, 8'h05);
    wr(8'd4, 8'h03);
    wr(8'd4, 8'h04);
    chk("sticky_fail", fail, 1);
    chk("sticky_cnt", cnt, 2);
    chk("sticky_fidx", fidx, 2);
    chk("sticky_fdata", fdata, 8'h05);
    // 3: strict vs relaxed addressing
    go(8, 1, 0);
    wr(8'd4, 8'h01);
    wr(8'd4, 8'h02);
    push(0, 2, 2, 2, 8'h33);
    wr(8'd6, 8'h33);
    go(8, 0, 0);
    wr(8'd4, 8'h01);
    wr(8'd4, 8'h02);
    wr(8'd6, 8'h03);
    chk("relaxed_cnt", cnt, 2);
    for (int i = 2; i < 7; i++) wr(8'd4, seq[i]);
    push(1, 0, 8, 0, 0);
    wr(8'd4, seq[7]);
    // 4: timeout fires 50 cycles after the last match
    go(8, 1, 50);
    push(0, 3, 1, 1, 0, 50);
    wr(8'd4, 8'h01);
    tick(60);
    go(2, 1, 50);
    wr(8'd4, 8'h01);
    tick(48);
    push(1, 0, 2, 0, 0);
    wr(8'd4, 8'h02);
    go(2, 1, 50);
    wr(8'd4, 8'h01);
    tick(49);
    chk("tmo_edge_busy", busy, 1);
    push(1, 0, 2, 0, 0);
    wr(8'd4, 8'h02);
    // 5: reset mid-run, then start colliding with cs
    go(8, 1, 0);
    wr(8'd4, 8'h01);
    wr(8'd4, 8'h02);
    wr(8'd4, 8'h03);
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_pass", pass, 0);
    chk("mid_rst_fail", fail, 0);
    chk("mid_rst_cnt", cnt, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_fidx", fidx, 0);
    chk("mid_rst_fdata", fdata, 0);
    go(8, 1, 0);
    wr(8'd4, 8'h01);
    wr(8'd4, 8'h02);
    cs = 1; addr = 8'd4; gpio = 8'h01;
    go(8, 1, 0);
    cs = 0;
    chk("restart_cnt", cnt, 0);
    chk("restart_busy", busy, 1);
    chk("restart_fail", fail, 0);
    run_full_pass();
    // 6: zero-length sequence, and table writes during RUN are ignored
    rst = 1;
    tick();
    rst = 0;
    push(1, 0, 0, 0, 0);
    go(0, 1, 0);
    go(8, 1, 0);
    wr(8'd4, 8'h01);
    exp_we = 1; exp_idx = 4'd1; exp_data = 8'h99;
    tick();
    exp_we = 0;
    for (int i = 1; i < 7; i++) wr(8'd4, seq[i]);
    push(1, 0, 8, 0, 0);
    wr(8'd4, seq[7]);
    go(8, 1, 0);
    run_full_pass();
    tick(3);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gpio_seq_checker.md
Name: gpio_seq_checker

Overview:
- Synthesisable successor to the simulation-only GPIO result monitor. Snoops the core's GPIO write bus (cs, address, data) and compares writes to a check address against a programmable expected-value sequence.
- Reports pass or fail with an error code, the failing index and data, and the match count.
- Generalised in data width, sequence depth, check address, address strictness and timeout.
- Sits beside as_top_mem on the GPIO outputs; used in FPGA self-test and in benches.

Parameters:
NR_GPIOS, 8, width of GPIO data bus
GPIO_ADDR_W, 8, width of GPIO address bus
DEPTH, 16, max expected-sequence entries (power of 2)
CHECK_ADDR, 4, GPIO address carrying test results
TIMEOUT_W, 20, timeout counter width

Ports:
clk_i  in  1  system clock, rising edge
rst_i  in  1  synchronous active-high reset
cs_i  in  1  GPIO write strobe, one cycle per write
gpioAddr_i  in  GPIO_ADDR_W  GPIO write address
gpio_i  in  NR_GPIOS  GPIO write data
exp_we_i  in  1  expected-table write enable
exp_idx_i  in  log2(DEPTH)  expected-table write index
exp_data_i  in  NR_GPIOS  expected-table write data
seq_len_i  in  log2(DEPTH)+1  number of entries to check, 0..DEPTH
strict_addr_i  in  1  1: cs to any other address is an error
timeout_i  in  TIMEOUT_W  max cycles between matches; 0 disables
start_i  in  1  arm checker (pulse)
busy_o  out  1  state RUN
done_o  out  1  state PASS or FAIL
pass_o  out  1  state PASS
fail_o  out  1  state FAIL
err_code_o  out  2  0 none, 1 data mismatch, 2 bad address, 3 timeout
match_cnt_o  out  log2(DEPTH)+1  entries matched so far
fail_idx_o  out  log2(DEPTH)+1  index being checked at failure
fail_data_o  out  NR_GPIOS  gpio_i captured at failure (0 for timeout)

Behaviour:
- Reset: state IDLE. All outputs 0, counters 0. Expected table contents undefined; the table is not cleared.
- The reset value of every output is 0.
- Table: synchronous write when exp_we_i=1 and state is not RUN. Writes during RUN are ignored.
- FSM states: IDLE, RUN, PASS, FAIL. All outputs are registered.
- IDLE/PASS/FAIL, start_i=1:
  - seq_len_i=0 -> PASS.
  - otherwise -> RUN.
  - On start: clear idx, match_cnt, tmo counter, err_code, fail fields.
  - Latch seq_len, strict and timeout at start.
- RUN, start_i=1: restart exactly as from IDLE. start has priority over cs in the same cycle; that cs is ignored.
- RUN, cs_i=1, gpioAddr_i==CHECK_ADDR:
  - gpio_i==table[idx] -> idx++, match_cnt++, tmo counter cleared.
  - If idx+1==seq_len -> PASS. pass_o is asserted the cycle after the final cs.
  - Mismatch -> FAIL, err 1, fail_idx=idx, fail_data=gpio_i.
- RUN, cs_i=1, other address:
  - strict=1 -> FAIL, err 2, capture idx and data.
  - strict=0 -> ignored; the timeout counter is not cleared.
- RUN, no qualifying match: tmo counter increments each cycle (saturating).
  - When timeout!=0 and counter reaches timeout-1 without a match -> FAIL, err 3, fail_data=0.
  - cs on the cycle the limit is hit: the cs is evaluated first. A match clears the counter and wins.
- PASS/FAIL are sticky until start_i or rst_i. cs_i is ignored in IDLE/PASS/FAIL.
- rst_i mid-RUN: return to IDLE next edge, all results cleared.
- Width rules:
  - Comparison is full NR_GPIOS width, exact; no masking or sign handling.
  - match_cnt never exceeds seq_len.
  - idx never wraps because PASS is entered at seq_len.

Test Plan:
1. Load table 1..7,0x80, seq_len=8, strict=1, timeout=0, start; issue cs at addr 4 with 1..7,0x80 -> pass_o=1 one cycle after the last cs, match_cnt=8, err=0.
2. Same table; third write 0x05 instead of 3 -> fail_o=1, err=1, fail_idx=2, fail_data=0x05, match_cnt=2; later cs writes leave results unchanged.
3. strict=1, cs to addr 6 after two matches -> err=2, fail_idx=2. Repeat with strict=0 -> the write is ignored and the sequence passes.
4. timeout=50, one match then no cs -> fail_o rises exactly 50 cycles after that match, err=3, fail_data=0. A match at cycle 49 -> no fail.
5. rst_i pulse mid-RUN after 3 matches -> all outputs 0, state IDLE. Second scenario: start_i asserted together with cs in RUN -> counters cleared and that cs ignored.
6. seq_len=0 start -> pass_o next cycle. exp_we_i during RUN does not change the compare (verify by rerun).
